// File: rtl/wrf_pkt_checker.sv
// WR-fabric frame receiver/checker: validates payload length against the ethertype
// field and payload content against a seeded 16-bit LFSR, with Wishbone-readable counters.
module wrf_pkt_checker #(
    parameter int g_cnt_width = 32,
    parameter int g_hdr_words = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_sel_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [15:0] snk_dat_i,
    output logic        snk_ack_o,
    output logic        snk_stall_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o
);

    localparam int HW = (g_hdr_words > 1) ? $clog2(g_hdr_words) : 1;
    localparam logic [HW-1:0] HDR_LAST = HW'(g_hdr_words - 1);
    localparam logic [g_cnt_width-1:0] CNT_ONE = {{(g_cnt_width-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEED, S_PAY, S_DONE} state_t;

    state_t                  state_q;
    state_t                  phase;
    logic                    armed_q;
    logic                    en_frame_q;
    logic                    short_q;
    logic                    data_err_q;
    logic                    snk_ack_q;
    logic [HW-1:0]           hdr_cnt_q;
    logic [HW-1:0]           hdr_base;
    logic [15:0]             exp_len_q;
    logic [15:0]             rx_len_q;
    logic [15:0]             rx_len_d;
    logic [16:0]             rx_sum;
    logic [15:0]             lfsr_q;
    logic [15:0]             lfsr_exp;
    logic [15:0]             last_len_q;
    logic [g_cnt_width-1:0]  good_q;
    logic [g_cnt_width-1:0]  err_len_q;
    logic [g_cnt_width-1:0]  err_data_q;
    logic                    ctrl_en_q;
    logic                    wb_ack_q;
    logic [31:0]             wb_dat_q;
    logic [31:0]             rd_data;
    logic                    accept;
    logic                    start;
    logic                    data_word;
    logic                    half;
    logic                    pay_ok;
    logic                    len_err;
    logic                    busy;
    logic                    wb_acc;
    logic                    wr_ctrl;
    logic                    clr;
    logic                    unused_bits;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign snk_stall_o = rst_i || (state_q == S_DONE);
    assign accept      = snk_cyc_i & snk_stb_i & ~snk_stall_o;
    // armed_q requires cyc to have been low since the last frame, so a cyc held
    // across reset cannot start a frame halfway through its words.
    assign start       = (state_q == S_IDLE) & snk_cyc_i & armed_q;
    assign data_word   = accept & snk_we_i & (snk_adr_i == 2'b00);
    assign phase       = start ? S_HDR : state_q;
    assign hdr_base    = start ? '0 : hdr_cnt_q;
    assign half        = (snk_sel_i == 2'b10);
    assign lfsr_exp    = lfsr_next(lfsr_q);
    assign pay_ok      = half ? (snk_dat_i[15:8] == lfsr_exp[15:8]) : (snk_dat_i == lfsr_exp);
    assign rx_sum      = {1'b0, rx_len_q} + (half ? 17'd1 : 17'd2);
    assign rx_len_d    = rx_sum[16] ? 16'hFFFF : rx_sum[15:0];
    assign len_err     = short_q | (rx_len_q != exp_len_q);
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            en_frame_q <= 1'b0;
            short_q    <= 1'b0;
            data_err_q <= 1'b0;
            snk_ack_q  <= 1'b0;
            hdr_cnt_q  <= '0;
            exp_len_q  <= '0;
            rx_len_q   <= '0;
            lfsr_q     <= '0;
        end else begin
            snk_ack_q <= accept;
            if (!snk_cyc_i) begin
                armed_q <= 1'b1;
            end else if (start) begin
                armed_q <= 1'b0;
            end
            if (start) begin
                state_q    <= S_HDR;
                en_frame_q <= ctrl_en_q;
                rx_len_q   <= '0;
                data_err_q <= 1'b0;
                hdr_cnt_q  <= '0;
            end
            case (phase)
                S_HDR: begin
                    if (!snk_cyc_i) begin
                        state_q <= S_DONE;
                        short_q <= 1'b1;
                    end else if (data_word) begin
                        if (hdr_base == HDR_LAST) begin
                            exp_len_q <= snk_dat_i;
                            state_q   <= S_SEED;
                        end else begin
                            hdr_cnt_q <= hdr_base + HW'(1);
                        end
                    end
                end
                S_SEED: begin
                    if (!snk_cyc_i) begin
                        state_q <= S_DONE;
                        short_q <= 1'b1;
                    end else if (data_word) begin
                        lfsr_q   <= snk_dat_i;
                        rx_len_q <= rx_len_d;
                        state_q  <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (!snk_cyc_i) begin
                        state_q <= S_DONE;
                        short_q <= 1'b0;
                    end else if (data_word) begin
                        // Advance from the expected value so one corrupt word is one error.
                        lfsr_q   <= lfsr_exp;
                        rx_len_q <= rx_len_d;
                        if (!pay_ok) begin
                            data_err_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: ;
            endcase
        end
    end

    assign wb_acc  = wb_cyc_i & wb_stb_i;
    assign wr_ctrl = wb_acc & wb_we_i & (wb_adr_i[4:2] == 3'd0);
    assign clr     = wr_ctrl & wb_dat_i[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            good_q     <= '0;
            err_len_q  <= '0;
            err_data_q <= '0;
            last_len_q <= '0;
            ctrl_en_q  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q <= wb_dat_i[0];
            end
            if (clr) begin
                good_q     <= '0;
                err_len_q  <= '0;
                err_data_q <= '0;
                last_len_q <= '0;
            end else if (state_q == S_DONE) begin
                last_len_q <= rx_len_q;
                if (en_frame_q) begin
                    if (len_err) begin
                        err_len_q <= sat_inc(err_len_q);
                    end else if (data_err_q) begin
                        err_data_q <= sat_inc(err_data_q);
                    end else begin
                        good_q <= sat_inc(good_q);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr_i[4:2])
            3'd0:    rd_data = {31'd0, ctrl_en_q};
            3'd1:    rd_data = 32'(good_q);
            3'd2:    rd_data = 32'(err_len_q);
            3'd3:    rd_data = 32'(err_data_q);
            3'd4:    rd_data = {15'd0, busy, last_len_q};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_q <= 1'b0;
            wb_dat_q <= '0;
        end else begin
            wb_ack_q <= wb_acc;
            wb_dat_q <= wb_acc ? rd_data : 32'd0;
        end
    end

    assign snk_ack_o   = snk_ack_q;
    assign wb_ack_o    = wb_ack_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_stall_o  = 1'b0;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:2]};

endmodule
